// File: rtl/data_mem_responder_pkg.sv
// +----------------------------------------------------------------------------
// | Module      : data_mem_responder_pkg
// | Description : Shared state encoding, word width and address-decode check
// |               for the data memory responder.
// | Revision    : 1.0 - initial release
// +----------------------------------------------------------------------------
`default_nettype none

package data_mem_responder_pkg;

    localparam int c_WORD_W = 32;

    typedef logic [1:0] state_t;

    localparam state_t c_ST_IDLE = 2'd0;
    localparam state_t c_ST_WAIT = 2'd1;
    localparam state_t c_ST_RESP = 2'd2;

    // Flags misaligned, below-base and past-end accesses.
    function automatic logic addr_err(
        input logic [31:0] addr,
        input logic [31:0] base,
        input logic [31:0] depth_words
    );
        logic [31:0] off;
        off = addr - base;
        return (addr[1:0] != 2'b00) || (addr < base) || ((off >> 2) >= depth_words);
    endfunction

endpackage

`default_nettype wire

// File: rtl/data_mem_responder_mem_array.sv
// +----------------------------------------------------------------------------
// | Module      : mem_array
// | Description : Single-port word RAM with write enable and registered read.
// | Revision    : 1.0 - initial release
// +----------------------------------------------------------------------------
`default_nettype none

module mem_array #(
    parameter int DEPTH  = 1024,
    parameter int WIDTH  = 32,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [WIDTH-1:0]  i_wdata,
    output logic [WIDTH-1:0]  o_rdata
);

    // Contents start at zero and are deliberately untouched by any reset.
    logic [WIDTH-1:0] r_mem [DEPTH] = '{default: '0};
    logic [WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/data_mem_responder.sv
// +----------------------------------------------------------------------------
// | Module      : data_mem_responder
// | Description : Wait-state load/store responder in front of a word RAM.
// | Revision    : 1.0 - initial release
// +----------------------------------------------------------------------------
`default_nettype none

module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_STATES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [31:0]         req_addr,
    input  logic [c_WORD_W-1:0] req_wdata,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [c_WORD_W-1:0] resp_rdata,
    output logic                resp_err,
    output logic                busy
);

    localparam int         c_IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [3:0] c_WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_t                r_state;
    logic [3:0]            r_cnt;
    logic                  r_write;
    logic                  r_err;
    logic [c_IDX_W-1:0]    r_index;
    logic [c_WORD_W-1:0]   r_wdata;
    logic                  r_resp_valid;
    logic                  r_resp_err;
    logic                  r_load_ok;

    logic                  w_accept;
    logic                  w_live_err;
    logic [c_IDX_W-1:0]    w_live_idx;
    logic                  w_enter_resp;
    logic                  w_op_write;
    logic                  w_op_err;
    logic [c_IDX_W-1:0]    w_op_idx;
    logic [c_WORD_W-1:0]   w_op_wdata;
    logic                  w_ram_we;
    logic                  w_ram_re;
    logic [c_WORD_W-1:0]   w_ram_rdata;

    assign req_ready  = reset && (r_state == c_ST_IDLE);
    assign busy       = (r_state != c_ST_IDLE);
    assign w_accept   = req_valid && req_ready;
    assign w_live_err = addr_err(req_addr, BASE_ADDR, 32'(DEPTH_WORDS));
    assign w_live_idx = c_IDX_W'((req_addr - BASE_ADDR) >> 2);

    // With zero wait states the RAM is accessed on the accepting edge itself,
    // so the live request feeds the RAM in IDLE and the latched copy otherwise.
    assign w_enter_resp = ((r_state == c_ST_IDLE) && w_accept && (WAIT_STATES == 0)) ||
                          ((r_state == c_ST_WAIT) && (r_cnt == 4'd0));
    assign w_op_write   = (r_state == c_ST_IDLE) ? req_write  : r_write;
    assign w_op_err     = (r_state == c_ST_IDLE) ? w_live_err : r_err;
    assign w_op_idx     = (r_state == c_ST_IDLE) ? w_live_idx : r_index;
    assign w_op_wdata   = (r_state == c_ST_IDLE) ? req_wdata  : r_wdata;
    assign w_ram_we     = w_enter_resp &&  w_op_write && !w_op_err;
    assign w_ram_re     = w_enter_resp && !w_op_write && !w_op_err;

    mem_array #(
        .DEPTH  (DEPTH_WORDS),
        .WIDTH  (c_WORD_W),
        .ADDR_W (c_IDX_W)
    ) u_mem_array (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_re    (w_ram_re),
        .i_addr  (w_op_idx),
        .i_wdata (w_op_wdata),
        .o_rdata (w_ram_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= c_ST_IDLE;
            r_cnt        <= 4'd0;
            r_write      <= 1'b0;
            r_err        <= 1'b0;
            r_index      <= '0;
            r_wdata      <= '0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_load_ok    <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        r_write <= req_write;
                        r_err   <= w_live_err;
                        r_index <= w_live_idx;
                        r_wdata <= req_wdata;
                        if (WAIT_STATES > 0) begin
                            r_state <= c_ST_WAIT;
                            r_cnt   <= c_WAIT_INIT;
                        end
                    end
                end
                c_ST_WAIT: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                c_ST_RESP: begin
                    if (resp_ready) begin
                        r_state      <= c_ST_IDLE;
                        r_resp_valid <= 1'b0;
                        r_resp_err   <= 1'b0;
                        r_load_ok    <= 1'b0;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase

            if (w_enter_resp) begin
                r_state      <= c_ST_RESP;
                r_resp_valid <= 1'b1;
                r_resp_err   <= w_op_err;
                r_load_ok    <= !w_op_write && !w_op_err;
            end
        end
    end

    assign resp_valid = r_resp_valid;
    assign resp_err   = r_resp_err;
    assign resp_rdata = r_load_ok ? w_ram_rdata : '0;

endmodule

`default_nettype wire

// File: tb/tb_data_mem_responder.sv
// +----------------------------------------------------------------------------
// | Module      : tb_data_mem_responder
// | Description : Directed self-checking bench for data_mem_responder.
// | Revision    : 1.0 - initial release
// +----------------------------------------------------------------------------
`default_nettype none

module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_write, resp_ready;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, resp_valid, resp_err, busy;
    logic [31:0] resp_rdata;

    logic        req_valid0, req_write0;
    logic [31:0] req_addr0, req_wdata0;
    logic        req_ready0, resp_valid0, resp_err0, busy0;
    logic [31:0] resp_rdata0;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(2), .BASE_ADDR(32'h0)) u_dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .busy(busy)
    );

    data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0), .BASE_ADDR(32'h0)) u_dut0 (
        .clk(clk), .reset(reset), .req_valid(req_valid0), .req_ready(req_ready0),
        .req_write(req_write0), .req_addr(req_addr0), .req_wdata(req_wdata0),
        .resp_valid(resp_valid0), .resp_ready(1'b1), .resp_rdata(resp_rdata0),
        .resp_err(resp_err0), .busy(busy0)
    );

    // Drives one request, scrambles the request inputs right after acceptance,
    // measures cycles to resp_valid, and retires the response.
    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                         output int lat, output logic [31:0] rd, output logic er);
        int guard;
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(posedge clk); #1; guard++;
        end
        @(posedge clk); #1;
        req_valid = 1'b0; req_addr = 32'h0000_0004; req_wdata = 32'hFFFF_FFFF; req_write = ~w;
        lat = 1;
        while (!resp_valid && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        rd = resp_rdata; er = resp_err;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL reset_req_ready: got %b expected 0", req_ready); end
        tests++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL reset_resp_valid: got %b expected 0", resp_valid); end
        tests++; if (resp_rdata !== 32'h0) begin fails++; $display("FAIL reset_resp_rdata: got %h expected 0", resp_rdata); end
        tests++; if (resp_err !== 1'b0) begin fails++; $display("FAIL reset_resp_err: got %b expected 0", resp_err); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_release_ready: got %b expected 1", req_ready); end
    endtask

    task automatic test_store_load();
        int lat; logic [31:0] rd; logic er;
        issue(1'b1, 32'h10, 32'hDEAD_BEEF, lat, rd, er);
        tests++; if (lat !== 3) begin fails++; $display("FAIL store_latency: got %0d expected 3", lat); end
        tests++; if (er !== 1'b0) begin fails++; $display("FAIL store_err: got %b expected 0", er); end
        tests++; if (rd !== 32'h0) begin fails++; $display("FAIL store_rdata: got %h expected 0", rd); end
        issue(1'b0, 32'h10, 32'h0, lat, rd, er);
        tests++; if (lat !== 3) begin fails++; $display("FAIL load_latency: got %0d expected 3", lat); end
        tests++; if (er !== 1'b0) begin fails++; $display("FAIL load_err: got %b expected 0", er); end
        tests++; if (rd !== 32'hDEAD_BEEF) begin fails++; $display("FAIL load_rdata: got %h expected deadbeef", rd); end
    endtask

    task automatic test_errors();
        int lat; logic [31:0] rd; logic er;
        issue(1'b1, 32'h0, 32'hA5A5_0001, lat, rd, er);
        issue(1'b0, 32'h13, 32'h0, lat, rd, er);
        tests++; if (er !== 1'b1) begin fails++; $display("FAIL misalign_err: got %b expected 1", er); end
        tests++; if (rd !== 32'h0) begin fails++; $display("FAIL misalign_rdata: got %h expected 0", rd); end
        issue(1'b0, 32'h1000, 32'h0, lat, rd, er);
        tests++; if (er !== 1'b1) begin fails++; $display("FAIL range_err: got %b expected 1", er); end
        tests++; if (rd !== 32'h0) begin fails++; $display("FAIL range_rdata: got %h expected 0", rd); end
        issue(1'b1, 32'h1, 32'h0000_0BAD, lat, rd, er);
        tests++; if (er !== 1'b1) begin fails++; $display("FAIL bad_store_err: got %b expected 1", er); end
        issue(1'b1, 32'h1000, 32'h0000_0BAD, lat, rd, er);
        issue(1'b0, 32'h0, 32'h0, lat, rd, er);
        tests++; if (rd !== 32'hA5A5_0001) begin fails++; $display("FAIL word0_intact: got %h expected a5a50001", rd); end
        tests++; if (er !== 1'b0) begin fails++; $display("FAIL word0_err: got %b expected 0", er); end
    endtask

    task automatic test_hold();
        int guard;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10; req_wdata = 32'h0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        guard = 0;
        while (!resp_valid && guard < 10) begin @(posedge clk); #1; guard++; end
        for (int i = 0; i < 5; i++) begin
            tests++; if (resp_valid !== 1'b1 || resp_rdata !== 32'hDEAD_BEEF || resp_err !== 1'b0)
                begin fails++; $display("FAIL hold_resp_%0d: got v=%b d=%h e=%b expected v=1 d=deadbeef e=0", i, resp_valid, resp_rdata, resp_err); end
            tests++; if (req_ready !== 1'b0 || busy !== 1'b1)
                begin fails++; $display("FAIL hold_status_%0d: got ready=%b busy=%b expected ready=0 busy=1", i, req_ready, busy); end
            @(posedge clk); #1;
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        tests++; if (resp_valid !== 1'b0 || resp_rdata !== 32'h0 || resp_err !== 1'b0)
            begin fails++; $display("FAIL hold_release_resp: got v=%b d=%h e=%b expected all 0", resp_valid, resp_rdata, resp_err); end
        tests++; if (busy !== 1'b0 || req_ready !== 1'b1)
            begin fails++; $display("FAIL hold_release_status: got busy=%b ready=%b expected busy=0 ready=1", busy, req_ready); end
    endtask

    task automatic test_reset_abort();
        int lat; logic [31:0] rd; logic er;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h1234_5678;
        @(posedge clk); #1;
        req_valid = 1'b0;
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL abort_in_wait: got busy=%b expected 1", busy); end
        #2 reset = 1'b0;
        #1;
        tests++; if (busy !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b0)
            begin fails++; $display("FAIL abort_async_clear: got busy=%b valid=%b ready=%b expected 0 0 0", busy, resp_valid, req_ready); end
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        issue(1'b0, 32'h20, 32'h0, lat, rd, er);
        tests++; if (rd !== 32'h0) begin fails++; $display("FAIL abort_no_commit: got %h expected 0", rd); end
        issue(1'b0, 32'h10, 32'h0, lat, rd, er);
        tests++; if (rd !== 32'hDEAD_BEEF) begin fails++; $display("FAIL abort_array_kept: got %h expected deadbeef", rd); end
    endtask

    task automatic test_latch();
        int lat; logic [31:0] rd; logic er;
        issue(1'b1, 32'h30, 32'h0000_0055, lat, rd, er);
        issue(1'b0, 32'h30, 32'h0, lat, rd, er);
        tests++; if (rd !== 32'h0000_0055) begin fails++; $display("FAIL latch_data: got %h expected 00000055", rd); end
        issue(1'b0, 32'h4, 32'h0, lat, rd, er);
        tests++; if (rd !== 32'h0) begin fails++; $display("FAIL latch_addr: got %h expected 0", rd); end
    endtask

    task automatic test_back_to_back();
        logic        w_tab [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [31:0] a_tab [7] = '{32'h40, 32'h44, 32'h40, 32'h44, 32'h40, 32'h40, 32'h45};
        logic [31:0] d_tab [7] = '{32'h1111_1111, 32'h2222_2222, 32'h0, 32'h0, 32'h3333_3333, 32'h0, 32'h0};
        logic [31:0] r_tab [7] = '{32'h0, 32'h0, 32'h1111_1111, 32'h2222_2222, 32'h0, 32'h3333_3333, 32'h0};
        logic        e_tab [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 7; i++) begin
            req_valid0 = 1'b1; req_write0 = w_tab[i]; req_addr0 = a_tab[i]; req_wdata0 = d_tab[i];
            @(posedge clk); #1;
            tests++; if (resp_valid0 !== 1'b1 || req_ready0 !== 1'b0)
                begin fails++; $display("FAIL b2b_latency_%0d: got valid=%b ready=%b expected 1 0", i, resp_valid0, req_ready0); end
            tests++; if (resp_rdata0 !== r_tab[i] || resp_err0 !== e_tab[i])
                begin fails++; $display("FAIL b2b_data_%0d: got d=%h e=%b expected d=%h e=%b", i, resp_rdata0, resp_err0, r_tab[i], e_tab[i]); end
            @(posedge clk); #1;
            tests++; if (resp_valid0 !== 1'b0 || req_ready0 !== 1'b1)
                begin fails++; $display("FAIL b2b_interval_%0d: got valid=%b ready=%b expected 0 1", i, resp_valid0, req_ready0); end
        end
        req_valid0 = 1'b0;
    endtask

    initial begin
        reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
        req_valid0 = 1'b0; req_write0 = 1'b0; req_addr0 = '0; req_wdata0 = '0;
        test_reset();
        test_store_load();
        test_errors();
        test_hold();
        test_reset_abort();
        test_latch();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, number of 32-bit words in the backing array (power of two, >=4).
REQ-002 Parameter WAIT_STATES, default 2, extra cycles between request acceptance and response (0..15).
REQ-003 Parameter BASE_ADDR, default 32'h0000_0000, byte address mapped to word 0.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 req_valid  input  1  datapath presents a load/store request.
REQ-007 req_ready  output  1  responder accepts a request this cycle.
REQ-008 req_write  input  1  1 = store, 0 = load.
REQ-009 req_addr  input  32  byte address (datapath ALUResult).
REQ-010 req_wdata  input  32  store data (datapath WriteData).
REQ-011 resp_valid  output  1  response available.
REQ-012 resp_ready  input  1  datapath consumes the response.
REQ-013 resp_rdata  output  32  load data (datapath ReadData); 0 for stores and errors.
REQ-014 resp_err  output  1  request was misaligned or out of range.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 FSM states SHALL be IDLE, WAIT, RESP.
REQ-017 req_ready SHALL equal 1 only in IDLE; a request is accepted on an edge where req_valid && req_ready.
REQ-018 On acceptance, write, addr, wdata SHALL be latched; later input changes have no effect.
REQ-019 On acceptance, next state SHALL be WAIT with counter = WAIT_STATES-1 when WAIT_STATES>0, else RESP.
REQ-020 In WAIT, the counter SHALL decrement each cycle; at 0, next state is RESP.
REQ-021 resp_valid SHALL rise exactly 1+WAIT_STATES cycles after the accepting edge.
REQ-022 Word index = (addr - BASE_ADDR) >> 2; error if addr[1:0] != 0, addr < BASE_ADDR, or index >= DEPTH_WORDS.
REQ-023 Store without error SHALL write the array on the edge entering RESP; store with error SHALL not modify the array.
REQ-024 Load without error SHALL capture array[index] on the edge entering RESP into resp_rdata; a load issued after a completed store to the same word returns the stored value.
REQ-025 resp_valid, resp_rdata, resp_err SHALL hold stable in RESP until resp_ready=1; that edge returns to IDLE and clears resp_valid, resp_rdata, resp_err.
REQ-026 Back-to-back: a new request is accepted no earlier than the cycle after RESP exits (minimum issue interval 2+WAIT_STATES cycles).
REQ-027 resp_ready while not in RESP SHALL be ignored.
REQ-028 Array contents SHALL be zero at elaboration.

Reset
REQ-029 reset=0 SHALL force IDLE immediately: req_ready=0 while asserted, then 1 on the first cycle after release; resp_valid=0, resp_rdata=0, resp_err=0, busy=0, counter=0.
REQ-030 reset during WAIT or RESP SHALL abort the transaction; a pending store not yet committed SHALL not be written; the array SHALL not be cleared by reset.

Structure
REQ-031 A shared package SHALL hold the state enum (IDLE/WAIT/RESP), WORD_W=32, and the address-decode error function.
REQ-032 One sub-module, mem_array (synchronous single-port word RAM, write-enable, registered read), SHALL hold storage; FSM and decode stay in data_mem_responder.

Verification
REQ-033 Store 0xDEAD_BEEF to 0x10, then load 0x10 -> resp_rdata=0xDEAD_BEEF, resp_err=0, resp_valid 3 cycles after each acceptance (WAIT_STATES=2).
REQ-034 Load 0x13 (misaligned) and load 4*DEPTH_WORDS -> resp_err=1, resp_rdata=0; subsequent load of word 0 returns its prior value, showing no corruption.
REQ-035 Hold resp_ready=0 for 5 cycles in RESP -> resp_valid/rdata/err stable, req_ready=0, busy=1; then resp_ready=1 -> IDLE next cycle.
REQ-036 Assert reset in WAIT of a store of 0x1234_5678 to 0x20 -> outputs cleared asynchronously; after release, load 0x20 returns 0.
REQ-037 WAIT_STATES=0 build: back-to-back store/load stream with resp_ready tied 1 -> one response every 2 cycles, latency 1 cycle, all data correct.
REQ-038 Change req_addr/req_wdata on the cycle after acceptance -> committed/returned values are those latched at acceptance.
